// File: rtl/simd_mac_array.sv
// SIMD signed multiply / multiply-accumulate lane array with a valid/ready handshake.
// The datapath is an operand register, MUL_STAGES product registers, and a final accumulate/shift/saturate register.
module simd_mac_array #(
    parameter int unsigned LANES      = 32,
    parameter int unsigned LANE_W     = 16,
    parameter int unsigned ACC_W      = 40,
    parameter int unsigned FRAC       = 0,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic                    acc_clr,
    input  logic [LANES*LANE_W-1:0] data_a,
    input  logic [LANES*LANE_W-1:0] data_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] data_out,
    output logic [LANES-1:0]        out_sat
);

    localparam int unsigned PROD_W = 2 * LANE_W;
    localparam int unsigned VEC_W  = LANES * LANE_W;
    localparam int unsigned LAST   = MUL_STAGES - 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-LANE_W+1){1'b1}}, {(LANE_W-1){1'b0}}};

    logic en;

    logic                     s0_valid_q, s0_valid_d;
    logic                     s0_mode_q,  s0_mode_d;
    logic                     s0_clr_q,   s0_clr_d;
    logic [VEC_W-1:0]         s0_a_q,     s0_a_d;
    logic [VEC_W-1:0]         s0_b_q,     s0_b_d;

    logic [MUL_STAGES-1:0]    mul_valid_q, mul_valid_d;
    logic [MUL_STAGES-1:0]    mul_mode_q,  mul_mode_d;
    logic [MUL_STAGES-1:0]    mul_clr_q,   mul_clr_d;
    logic signed [PROD_W-1:0] mul_p_q [MUL_STAGES][LANES];
    logic signed [PROD_W-1:0] mul_p_d [MUL_STAGES][LANES];

    logic signed [ACC_W-1:0]  acc_q [LANES];
    logic signed [ACC_W-1:0]  acc_d [LANES];

    logic                     out_valid_q, out_valid_d;
    logic [VEC_W-1:0]         data_out_q,  data_out_d;
    logic [LANES-1:0]         out_sat_q,   out_sat_d;

    logic signed [PROD_W-1:0] prod_c  [LANES];
    logic signed [ACC_W-1:0]  ext_c   [LANES];
    logic signed [ACC_W-1:0]  v_c     [LANES];
    logic signed [ACC_W-1:0]  s_c     [LANES];
    logic [LANE_W-1:0]        res_c   [LANES];
    logic [LANES-1:0]         lsat_c;

    // A full output register only frees up when downstream takes it.
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign out_sat   = out_sat_q;

    // Per-lane multiply, accumulate select, fixed-point shift and saturation.
    always_comb begin
        lsat_c = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_c[i] = PROD_W'($signed(s0_a_q[i*LANE_W +: LANE_W]))
                      * PROD_W'($signed(s0_b_q[i*LANE_W +: LANE_W]));
            ext_c[i]  = ACC_W'(mul_p_q[LAST][i]);
            if (!mul_mode_q[LAST] || mul_clr_q[LAST]) begin
                v_c[i] = ext_c[i];
            end else begin
                v_c[i] = acc_q[i] + ext_c[i];
            end
            s_c[i] = v_c[i] >>> FRAC;
            if (s_c[i] > SAT_MAX) begin
                res_c[i]  = SAT_MAX[LANE_W-1:0];
                lsat_c[i] = 1'b1;
            end else if (s_c[i] < SAT_MIN) begin
                res_c[i]  = SAT_MIN[LANE_W-1:0];
                lsat_c[i] = 1'b1;
            end else begin
                res_c[i]  = s_c[i][LANE_W-1:0];
            end
        end
    end

    // Next state: everything advances together under the global enable.
    always_comb begin
        s0_valid_d  = s0_valid_q;
        s0_mode_d   = s0_mode_q;
        s0_clr_d    = s0_clr_q;
        s0_a_d      = s0_a_q;
        s0_b_d      = s0_b_q;
        mul_valid_d = mul_valid_q;
        mul_mode_d  = mul_mode_q;
        mul_clr_d   = mul_clr_q;
        mul_p_d     = mul_p_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        out_sat_d   = out_sat_q;

        if (en) begin
            s0_valid_d     = in_valid;
            s0_mode_d      = mode;
            s0_clr_d       = acc_clr;
            s0_a_d         = data_a;
            s0_b_d         = data_b;

            mul_valid_d[0] = s0_valid_q;
            mul_mode_d[0]  = s0_mode_q;
            mul_clr_d[0]   = s0_clr_q;
            mul_p_d[0]     = prod_c;
            for (int k = 1; k < MUL_STAGES; k++) begin
                mul_valid_d[k] = mul_valid_q[k-1];
                mul_mode_d[k]  = mul_mode_q[k-1];
                mul_clr_d[k]   = mul_clr_q[k-1];
                mul_p_d[k]     = mul_p_q[k-1];
            end

            out_valid_d = mul_valid_q[LAST];
            if (mul_valid_q[LAST]) begin
                out_sat_d = lsat_c;
                for (int i = 0; i < LANES; i++) begin
                    data_out_d[i*LANE_W +: LANE_W] = res_c[i];
                    if (mul_mode_q[LAST]) begin
                        acc_d[i] = v_c[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s0_mode_q   <= 1'b0;
            s0_clr_q    <= 1'b0;
            s0_a_q      <= '0;
            s0_b_q      <= '0;
            mul_valid_q <= '0;
            mul_mode_q  <= '0;
            mul_clr_q   <= '0;
            mul_p_q     <= '{default: '0};
            acc_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            out_sat_q   <= '0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_mode_q   <= s0_mode_d;
            s0_clr_q    <= s0_clr_d;
            s0_a_q      <= s0_a_d;
            s0_b_q      <= s0_b_d;
            mul_valid_q <= mul_valid_d;
            mul_mode_q  <= mul_mode_d;
            mul_clr_q   <= mul_clr_d;
            mul_p_q     <= mul_p_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_simd_mac_array.sv
// Scoreboard bench for simd_mac_array: two instances (FRAC=0 and FRAC=8) share stimulus and
// run in lockstep; a lane model pushes expected results on acceptance and they are popped on output.
module tb_simd_mac_array;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned VEC_W  = LANES * LANE_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             mode;
    logic             acc_clr;
    logic [VEC_W-1:0] data_a;
    logic [VEC_W-1:0] data_b;
    logic             out_ready;

    logic             in_ready,  in_ready8;
    logic             out_valid, out_valid8;
    logic [VEC_W-1:0] data_out,  data_out8;
    logic [LANES-1:0] out_sat,   out_sat8;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [VEC_W-1:0] d0;
        logic [LANES-1:0] s0;
        logic [VEC_W-1:0] d8;
        logic [LANES-1:0] s8;
    } exp_t;

    exp_t                exp_q[$];
    exp_t                e_push;
    exp_t                e_pop;
    logic signed [39:0]  acc_m [LANES];
    logic signed [15:0]  ta, tbv;
    logic signed [31:0]  tp;
    logic signed [39:0]  pe, v;
    logic [16:0]         r0, r8;

    always #5 clk = ~clk;

    simd_mac_array #(.LANES(LANES), .LANE_W(LANE_W), .ACC_W(40), .FRAC(0), .MUL_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .acc_clr(acc_clr), .data_a(data_a), .data_b(data_b), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .out_sat(out_sat)
    );

    simd_mac_array #(.LANES(LANES), .LANE_W(LANE_W), .ACC_W(40), .FRAC(8), .MUL_STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .mode(mode),
        .acc_clr(acc_clr), .data_a(data_a), .data_b(data_b), .out_valid(out_valid8),
        .out_ready(out_ready), .data_out(data_out8), .out_sat(out_sat8)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // {sat, result} for a lane value after an arithmetic shift by f.
    function automatic logic [16:0] sat_lane(input logic signed [39:0] val, input int f);
        logic signed [39:0] s;
        s = val >>> f;
        if (s > 40'sd32767)       return {1'b1, 16'h7FFF};
        else if (s < -40'sd32768) return {1'b1, 16'h8000};
        else                      return {1'b0, s[15:0]};
    endfunction

    function automatic logic [VEC_W-1:0] rep(input logic [15:0] x);
        return {LANES{x}};
    endfunction

    // Output checks and model pushes, all sampled away from the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < LANES; i++) acc_m[i] = '0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    e_pop = exp_q[0];
                    chk("data_out",       64'(data_out),  64'(e_pop.d0));
                    chk("out_sat",        64'(out_sat),   64'(e_pop.s0));
                    chk("data_out_frac8", 64'(data_out8), 64'(e_pop.d8));
                    chk("out_sat_frac8",  64'(out_sat8),  64'(e_pop.s8));
                    chk("valid_frac8",    64'(out_valid8), 64'd1);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < LANES; i++) begin
                    ta  = data_a[16*i +: 16];
                    tbv = data_b[16*i +: 16];
                    tp  = ta * tbv;
                    pe  = {{8{tp[31]}}, tp};
                    if (mode) begin
                        v = acc_clr ? pe : acc_m[i] + pe;
                        acc_m[i] = v;
                    end else begin
                        v = pe;
                    end
                    r0 = sat_lane(v, 0);
                    r8 = sat_lane(v, 8);
                    e_push.d0[16*i +: 16] = r0[15:0];
                    e_push.s0[i]          = r0[16];
                    e_push.d8[16*i +: 16] = r8[15:0];
                    e_push.s8[i]          = r8[16];
                end
                exp_q.push_back(e_push);
            end
        end
    end

    task automatic send(input logic m, input logic c, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
        int g = 0;
        in_valid = 1'b1;
        mode     = m;
        acc_clr  = c;
        data_a   = a;
        data_b   = b;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int g;
        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        acc_clr   = 1'b0;
        data_a    = '0;
        data_b    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out",  64'(data_out),  64'd0);
        chk("rst_out_sat",   64'(out_sat),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Basic multiply and pipeline latency.
        send(1'b0, 1'b0, rep(16'd3), rep(16'hFFFB));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd3);
        drain();

        // Saturation corners per lane.
        send(1'b0, 1'b0, {16'd2, 16'h8000, 16'h8000, 16'h7FFF}, {16'd4, 16'h8000, 16'h7FFF, 16'h7FFF});
        drain();

        // MAC chain with an interleaved plain multiply.
        send(1'b1, 1'b1, rep(16'd100), rep(16'd2));
        send(1'b1, 1'b0, rep(16'd100), rep(16'd2));
        send(1'b0, 1'b0, rep(16'd1),   rep(16'd1));
        send(1'b1, 1'b0, rep(16'd100), rep(16'd2));
        send(1'b1, 1'b0, rep(16'd100), rep(16'd2));
        drain();

        // Fixed-point operands; the FRAC=8 instance floors toward -inf.
        send(1'b0, 1'b0, rep(16'h0180), rep(16'h0200));
        send(1'b0, 1'b0, rep(16'hFFFF), rep(16'h0001));
        send(1'b0, 1'b0, {16'hFF00, 16'h7FFF, 16'hFFFF, 16'h0081}, {16'h0003, 16'h7FFF, 16'hFFFF, 16'hFF00});
        drain();

        // Backpressure during a MAC stream.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(1'b1, (i == 0), rep(16'(7 * (i + 1))), rep(16'hFFFD));
                end
            end
            begin
                g = 0;
                while (!out_valid && g < 50) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready",  64'(in_ready),  64'd0);
                    chk("stall_in_ready8", 64'(in_ready8), 64'd0);
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with beats in flight and nonzero accumulators.
        send(1'b1, 1'b0, rep(16'd5), rep(16'd5));
        send(1'b1, 1'b0, rep(16'd6), rep(16'd6));
        send(1'b1, 1'b0, rep(16'd7), rep(16'd7));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        send(1'b1, 1'b0, rep(16'd1), rep(16'd1));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
